// File: rtl/garage_opener_gen2.sv
// Second-generation garage door opener: Moore FSM with button edge detect,
// travel timeout fault, optional auto-close and a motor-off dwell before reversal.
module garage_opener_gen2 #(
    parameter int unsigned CNT_W            = 16,
    parameter int unsigned TRAVEL_MAX       = 1000,
    parameter int unsigned AUTOCLOSE_EN     = 1,
    parameter int unsigned AUTOCLOSE_CYCLES = 500,
    parameter int unsigned REVERSE_PAUSE    = 4
) (
    input  logic       clk,
    input  logic       r,
    input  logic       b,
    input  logic       c,
    input  logic       o,
    input  logic       s,
    output logic       d,
    output logic       u,
    output logic       fault,
    output logic [2:0] State
);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_CLOSED  = 3'd1,
        ST_OPENING = 3'd2,
        ST_OPEN    = 3'd3,
        ST_CLOSING = 3'd4,
        ST_PAUSE   = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_MAX - 1);
    localparam logic [CNT_W-1:0] AC_LAST     = CNT_W'(AUTOCLOSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST  = CNT_W'(REVERSE_PAUSE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic             AC_ON       = (AUTOCLOSE_EN != 0);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             b_q_r;
    logic             b_rise_s;
    logic             cnt_zero_s;
    logic             both_limits_s;
    logic             u_r;
    logic             d_r;
    logic             fault_r;

    // Next-state selection; cnt_zero_s restarts the OPEN dwell while obstructed.
    always_comb begin
        next_state_s  = state_r;
        cnt_zero_s    = 1'b0;
        b_rise_s      = b & ~b_q_r;
        both_limits_s = c & o;
        case (state_r)
            ST_INIT: begin
                if (c)      next_state_s = ST_CLOSED;
                else if (o) next_state_s = ST_OPEN;
                else        next_state_s = ST_OPENING;
            end
            ST_CLOSED: begin
                if (both_limits_s) next_state_s = ST_FAULT;
                else if (b_rise_s) next_state_s = ST_OPENING;
                else               next_state_s = ST_CLOSED;
            end
            ST_OPENING: begin
                if (both_limits_s)            next_state_s = ST_FAULT;
                else if (o)                   next_state_s = ST_OPEN;
                else if (cnt_r == TRAVEL_LAST) next_state_s = ST_FAULT;
                else                          next_state_s = ST_OPENING;
            end
            ST_OPEN: begin
                if (both_limits_s)                       next_state_s = ST_FAULT;
                else if (b_rise_s && !s)                 next_state_s = ST_CLOSING;
                else if (AC_ON && !s && cnt_r == AC_LAST) next_state_s = ST_CLOSING;
                else if (s)                              cnt_zero_s   = 1'b1;
                else                                     next_state_s = ST_OPEN;
            end
            ST_CLOSING: begin
                if (both_limits_s)             next_state_s = ST_FAULT;
                else if (s || b_rise_s)        next_state_s = ST_PAUSE;
                else if (c)                    next_state_s = ST_CLOSED;
                else if (cnt_r == TRAVEL_LAST) next_state_s = ST_FAULT;
                else                           next_state_s = ST_CLOSING;
            end
            ST_PAUSE: begin
                if (both_limits_s)            next_state_s = ST_FAULT;
                else if (cnt_r == PAUSE_LAST) next_state_s = ST_OPENING;
                else                          next_state_s = ST_PAUSE;
            end
            ST_FAULT: begin
                if (b_rise_s) next_state_s = ST_INIT;
                else          next_state_s = ST_FAULT;
            end
            default: next_state_s = ST_FAULT;
        endcase
    end

    // State, dwell counter, button history and outputs decoded from the next state.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_r <= ST_INIT;
            cnt_r   <= {CNT_W{1'b0}};
            b_q_r   <= 1'b0;
            u_r     <= 1'b0;
            d_r     <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            b_q_r   <= b;
            state_r <= next_state_s;
            if ((next_state_s != state_r) || cnt_zero_s) cnt_r <= {CNT_W{1'b0}};
            else if (cnt_r != CNT_MAX)                   cnt_r <= cnt_r + CNT_ONE;
            else                                         cnt_r <= cnt_r;
            u_r     <= (next_state_s == ST_OPENING);
            d_r     <= (next_state_s == ST_CLOSING);
            fault_r <= (next_state_s == ST_FAULT);
        end
    end

    assign u     = u_r;
    assign d     = d_r;
    assign fault = fault_r;
    assign State = state_r;

endmodule
